// File: rtl/tag_search.sv
// tag_search: small tag table with a sequential, one-entry-per-cycle search engine.
// Entries are written at any time. A search scans ascending indices from 0 and
// stops at the first valid entry whose tag equals the key latched at search start.
module tag_search #(
    parameter int NENT = 8,
    parameter int TW   = 6,
    localparam int IW  = (NENT > 1) ? $clog2(NENT) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [TW-1:0] wr_tag,
    input  logic          inv_all,
    input  logic          srch_req,
    input  logic [TW-1:0] srch_key,
    output logic          busy,
    output logic          done,
    output logic          hit,
    output logic [IW-1:0] hit_idx
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NENT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [TW-1:0] key, key_nx;
    logic          done_nx;
    logic          hit_nx;
    logic [IW-1:0] hit_idx_nx;

    logic [TW-1:0] tags [NENT];
    logic [NENT-1:0] valid;
    logic          match;

    // The entry under the scan pointer is compared against registered contents,
    // so a write landing on the same edge never affects this cycle's compare.
    assign match = valid[idx] & (tags[idx] == key);
    assign busy  = (state == SCAN);

    // Next-state and registered-output logic for the search engine.
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        key_nx     = key;
        done_nx    = 1'b0;
        hit_nx     = hit;
        hit_idx_nx = hit_idx;
        case (state)
            IDLE: begin
                // A request in the done cycle is dropped: no queueing.
                if (srch_req && !done) begin
                    state_nx   = SCAN;
                    idx_nx     = '0;
                    key_nx     = srch_key;
                    hit_nx     = 1'b0;
                    hit_idx_nx = '0;
                end
            end
            SCAN: begin
                if (match) begin
                    state_nx   = IDLE;
                    done_nx    = 1'b1;
                    hit_nx     = 1'b1;
                    hit_idx_nx = idx;
                end else if (idx == LAST_IDX) begin
                    state_nx   = IDLE;
                    done_nx    = 1'b1;
                    hit_nx     = 1'b0;
                    hit_idx_nx = '0;
                end else begin
                    idx_nx = idx + IW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Control state and result registers; reset aborts any scan silently.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            done    <= 1'b0;
            hit     <= 1'b0;
            hit_idx <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            done    <= done_nx;
            hit     <= hit_nx;
            hit_idx <= hit_idx_nx;
        end
    end

    // Search key holder; only loaded when a search is accepted.
    always_ff @(posedge clk) begin
        key <= key_nx;
    end

    // Valid bits: invalidate-all takes priority over a simultaneous write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= '0;
        end else begin
            if (wr_en) begin
                valid[wr_idx] <= 1'b1;
            end
            if (inv_all) begin
                valid <= '0;
            end
        end
    end

    // Tag storage is not cleared by reset; writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            tags[wr_idx] <= wr_tag;
        end
    end

endmodule

// File: tb/tb_tag_search.sv
// Testbench for tag_search: directed scenarios plus randomized searches checked
// against a table-level reference model kept in the bench.
module tb_tag_search;

    localparam int NENT = 8;
    localparam int TW   = 6;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [2:0]    wr_idx;
    logic [TW-1:0] wr_tag;
    logic          inv_all;
    logic          srch_req;
    logic [TW-1:0] srch_key;
    logic          busy;
    logic          done;
    logic          hit;
    logic [2:0]    hit_idx;

    // Reference table contents as seen by the design after each edge.
    logic [TW-1:0] mt_tag [NENT];
    bit            mt_valid [NENT];

    int cmps = 0;
    int errs = 0;

    tag_search #(.NENT(NENT), .TW(TW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .inv_all  (inv_all),
        .srch_req (srch_req),
        .srch_key (srch_key),
        .busy     (busy),
        .done     (done),
        .hit      (hit),
        .hit_idx  (hit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, updating the reference table from the inputs present at it.
    task automatic tick();
        if (!reset_n) begin
            for (int i = 0; i < NENT; i++) mt_valid[i] = 0;
        end else begin
            if (wr_en) begin
                mt_tag[wr_idx]   = wr_tag;
                mt_valid[wr_idx] = 1;
            end
            if (inv_all) begin
                for (int i = 0; i < NENT; i++) mt_valid[i] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int i, input logic [TW-1:0] t);
        wr_en  = 1'b1;
        wr_idx = i[2:0];
        wr_tag = t;
        tick();
        wr_en  = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < NENT; i++) wr(i, TW'(8 + i));
    endtask

    // Run one search. Entry c-1 is compared in cycle c using the table as it
    // stands before that cycle's writes; the first valid equal entry wins.
    // wc/wi/wt: forced write in cycle wc; ic: inv_all in cycle ic; rnd: random
    // background writes, invalidations and ignored requests during the scan.
    task automatic do_search(input logic [TW-1:0] k, input bit rnd, input int wc,
                             input int wi, input logic [TW-1:0] wt, input int ic,
                             output int dc);
        bit found;
        int hidx;
        int c;
        found = 0;
        hidx  = 0;
        srch_req = 1'b1;
        srch_key = k;
        tick();
        srch_req = 1'b0;
        for (c = 1; c <= NENT; c++) begin
            cmps++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                $display("FAIL scan_busy key=%0o cycle=%0d: busy=%b done=%b, want busy=1 done=0",
                         k, c, busy, done);
                errs++;
            end
            if (c == 1) begin
                cmps++;
                if (hit !== 1'b0 || hit_idx !== 3'd0) begin
                    $display("FAIL hit_clear key=%0o: hit=%b hit_idx=%0d, want 0/0", k, hit, hit_idx);
                    errs++;
                end
            end
            if (mt_valid[c-1] && mt_tag[c-1] == k) begin
                found = 1;
                hidx  = c - 1;
            end
            srch_key = TW'($urandom);
            srch_req = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            wr_en    = 1'b0;
            inv_all  = 1'b0;
            if (rnd) begin
                wr_en   = 1'($urandom_range(0, 1));
                wr_idx  = 3'($urandom_range(0, NENT - 1));
                wr_tag  = TW'($urandom_range(0, 7));
                inv_all = ($urandom_range(0, 15) == 0);
            end
            if (c == wc) begin
                wr_en  = 1'b1;
                wr_idx = wi[2:0];
                wr_tag = wt;
            end
            if (c == ic) inv_all = 1'b1;
            tick();
            if (found) break;
        end
        wr_en    = 1'b0;
        inv_all  = 1'b0;
        srch_req = 1'b0;
        dc = found ? hidx + 2 : NENT + 1;
        cmps++;
        if (done !== 1'b1 || busy !== 1'b0 || hit !== found || hit_idx !== 3'(found ? hidx : 0)) begin
            $display("FAIL result key=%0o: done=%b busy=%b hit=%b hit_idx=%0d, want 1/0/%b/%0d",
                     k, done, busy, hit, hit_idx, found, found ? hidx : 0);
            errs++;
        end
        // A request during the done cycle must be dropped.
        srch_req = 1'b1;
        srch_key = k;
        tick();
        srch_req = 1'b0;
        cmps++;
        if (done !== 1'b0 || busy !== 1'b0 || hit !== found || hit_idx !== 3'(found ? hidx : 0)) begin
            $display("FAIL post_done key=%0o: done=%b busy=%b hit=%b hit_idx=%0d, want 0/0/%b/%0d",
                     k, done, busy, hit, hit_idx, found, found ? hidx : 0);
            errs++;
        end
    endtask

    task automatic test_reset();
        int dc;
        reset_n = 1'b0;
        tick();
        tick();
        cmps++;
        if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || hit_idx !== 3'd0) begin
            $display("FAIL reset_state: busy=%b done=%b hit=%b hit_idx=%0d, want all 0",
                     busy, done, hit, hit_idx);
            errs++;
        end
        // First request on the first edge out of reset, empty table.
        reset_n = 1'b1;
        do_search(6'o21, 0, 0, 0, '0, 0, dc);
        cmps++;
        if (dc != 9 || hit !== 1'b0) begin
            $display("FAIL first_req_miss: done_cycle=%0d hit=%b, want 9/0", dc, hit);
            errs++;
        end
    endtask

    task automatic test_table();
        int dc;
        load_table();
        do_search(6'o13, 0, 0, 0, '0, 0, dc);
        cmps++;
        if (dc != 5 || hit !== 1'b1 || hit_idx !== 3'd3) begin
            $display("FAIL table_hit: done_cycle=%0d hit=%b hit_idx=%0d, want 5/1/3", dc, hit, hit_idx);
            errs++;
        end
        do_search(6'o77, 0, 0, 0, '0, 0, dc);
        cmps++;
        if (dc != 9 || hit !== 1'b0 || hit_idx !== 3'd0) begin
            $display("FAIL table_miss: done_cycle=%0d hit=%b hit_idx=%0d, want 9/0/0", dc, hit, hit_idx);
            errs++;
        end
    endtask

    task automatic test_duplicate();
        int dc;
        load_table();
        wr(2, 6'o42);
        wr(5, 6'o42);
        do_search(6'o42, 0, 0, 0, '0, 0, dc);
        cmps++;
        if (dc != 4 || hit !== 1'b1 || hit_idx !== 3'd2) begin
            $display("FAIL dup_lowest: done_cycle=%0d hit=%b hit_idx=%0d, want 4/1/2", dc, hit, hit_idx);
            errs++;
        end
        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        do_search(6'o42, 0, 0, 0, '0, 0, dc);
        cmps++;
        if (dc != 9 || hit !== 1'b0) begin
            $display("FAIL dup_after_inv: done_cycle=%0d hit=%b, want 9/0", dc, hit);
            errs++;
        end
    endtask

    task automatic test_write_during_scan();
        int dc;
        load_table();
        // Entry 6 written while entry 1 is compared: seen later in the scan.
        do_search(6'o55, 0, 2, 6, 6'o55, 0, dc);
        cmps++;
        if (dc != 8 || hit !== 1'b1 || hit_idx !== 3'd6) begin
            $display("FAIL wr_ahead: done_cycle=%0d hit=%b hit_idx=%0d, want 8/1/6", dc, hit, hit_idx);
            errs++;
        end
        // Overwriting the compared entry: old matching value still wins.
        wr(6, 6'o16);
        wr(3, 6'o55);
        do_search(6'o55, 0, 4, 3, 6'o00, 0, dc);
        cmps++;
        if (dc != 5 || hit !== 1'b1 || hit_idx !== 3'd3) begin
            $display("FAIL wr_same_old_hit: done_cycle=%0d hit=%b hit_idx=%0d, want 5/1/3", dc, hit, hit_idx);
            errs++;
        end
        // Writing a matching value into the compared entry: old value misses.
        do_search(6'o55, 0, 4, 3, 6'o55, 0, dc);
        cmps++;
        if (dc != 9 || hit !== 1'b0) begin
            $display("FAIL wr_same_old_miss: done_cycle=%0d hit=%b, want 9/0", dc, hit);
            errs++;
        end
    endtask

    task automatic test_inv_during_scan();
        int dc;
        wr(3, 6'o13);
        wr(5, 6'o55);
        do_search(6'o55, 0, 0, 0, '0, 3, dc);
        cmps++;
        if (dc != 9 || hit !== 1'b0) begin
            $display("FAIL inv_mid_scan: done_cycle=%0d hit=%b, want 9/0", dc, hit);
            errs++;
        end
    endtask

    task automatic test_reset_mid_scan();
        int dc;
        load_table();
        srch_req = 1'b1;
        srch_key = 6'o17;
        tick();
        srch_req = 1'b0;
        tick();
        // Reset with every other control input active in the same cycle.
        reset_n  = 1'b0;
        wr_en    = 1'b1;
        wr_idx   = 3'd0;
        wr_tag   = 6'o55;
        inv_all  = 1'b1;
        srch_req = 1'b1;
        tick();
        reset_n  = 1'b1;
        wr_en    = 1'b0;
        inv_all  = 1'b0;
        srch_req = 1'b0;
        cmps++;
        if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || hit_idx !== 3'd0) begin
            $display("FAIL reset_mid_scan: busy=%b done=%b hit=%b hit_idx=%0d, want all 0",
                     busy, done, hit, hit_idx);
            errs++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            cmps++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL no_done_after_reset cycle=%0d: done=%b busy=%b, want 0/0", i, done, busy);
                errs++;
            end
        end
        do_search(6'o10, 0, 0, 0, '0, 0, dc);
        cmps++;
        if (dc != 9 || hit !== 1'b0) begin
            $display("FAIL invalid_after_reset: done_cycle=%0d hit=%b, want 9/0", dc, hit);
            errs++;
        end
    endtask

    task automatic test_random();
        int dc;
        for (int n = 0; n < 30; n++) begin
            for (int j = 0; j < 3; j++) begin
                wr($urandom_range(0, NENT - 1), TW'($urandom_range(0, 7)));
            end
            if ($urandom_range(0, 7) == 0) begin
                inv_all = 1'b1;
                tick();
                inv_all = 1'b0;
            end
            do_search(TW'($urandom_range(0, 7)), 1, 0, 0, '0, 0, dc);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_tag   = '0;
        inv_all  = 1'b0;
        srch_req = 1'b0;
        srch_key = '0;
        for (int i = 0; i < NENT; i++) begin
            mt_valid[i] = 0;
            mt_tag[i]   = '0;
        end
        test_reset();
        test_table();
        test_duplicate();
        test_write_during_scan();
        test_inv_during_scan();
        test_reset_mid_scan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
